// File: rtl/apb_gpio_pkg.sv
// rtl/apb_gpio_pkg.sv - shared register offsets and decode types for the APB GPIO block
package apb_gpio_pkg;

    localparam int ADDR_DEC_W = 7;

    localparam logic [ADDR_DEC_W-1:0] OFF_DIN      = 7'h00;
    localparam logic [ADDR_DEC_W-1:0] OFF_DOUT     = 7'h04;
    localparam logic [ADDR_DEC_W-1:0] OFF_DIR      = 7'h08;
    localparam logic [ADDR_DEC_W-1:0] OFF_RISE_EN  = 7'h0C;
    localparam logic [ADDR_DEC_W-1:0] OFF_FALL_EN  = 7'h10;
    localparam logic [ADDR_DEC_W-1:0] OFF_STATUS   = 7'h14;
    localparam logic [ADDR_DEC_W-1:0] OFF_DOUT_SET = 7'h18;
    localparam logic [ADDR_DEC_W-1:0] OFF_DOUT_CLR = 7'h1C;

    // Register index is the word offset within the 0x00..0x1C window
    typedef enum logic [2:0] {
        REG_DIN      = 3'd0,
        REG_DOUT     = 3'd1,
        REG_DIR      = 3'd2,
        REG_RISE_EN  = 3'd3,
        REG_FALL_EN  = 3'd4,
        REG_STATUS   = 3'd5,
        REG_DOUT_SET = 3'd6,
        REG_DOUT_CLR = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - pad input synchroniser with edge detection
module gpio_in_sync #(
    parameter int NPIN        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            pCLK,
    input  logic            pRESET,
    input  logic [NPIN-1:0] gpio_in,
    output logic [NPIN-1:0] sync_in,
    output logic [NPIN-1:0] rise,
    output logic [NPIN-1:0] fall
);

    logic [NPIN-1:0] chain [SYNC_STAGES];
    logic [NPIN-1:0] prev;

    // Metastability chain; stage 0 is the only flop that sees the raw pad
    always_ff @(posedge pCLK) begin
        if (pRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign sync_in = chain[SYNC_STAGES-1];

    // One-cycle history of the synchronised value for edge detection
    always_ff @(posedge pCLK) begin
        if (pRESET) prev <= '0;
        else        prev <= sync_in;
    end

    assign rise = sync_in & ~prev;
    assign fall = ~sync_in & prev;

endmodule

// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - APB3 GPIO with direction, set/clear and edge interrupts
module apb_gpio_irq
    import apb_gpio_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NPIN        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic            pCLK,
    input  logic            pRESET,
    input  logic [AW-1:0]   pADDR,
    input  logic            pSEL,
    input  logic            pENABLE,
    input  logic            pWRITE,
    input  logic [DW-1:0]   pWDATA,
    output logic [DW-1:0]   pRDATA,
    output logic            pREADY,
    output logic            pSLVERR,
    input  logic [NPIN-1:0] gpio_in,
    output logic [NPIN-1:0] gpio_out,
    output logic [NPIN-1:0] gpio_oe,
    output logic            irq
);

    logic [NPIN-1:0] dout_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [NPIN-1:0] sync_in, rise, fall;
    logic [NPIN-1:0] wdata_n, events, w1c;
    logic [3:0]      cnt_q;
    logic            access, err, wr_commit;
    logic [ADDR_DEC_W-1:0] off;
    gpio_reg_e       reg_idx;

    logic unused_bits;
    assign unused_bits = ^{pADDR, pWDATA};

    gpio_in_sync #(
        .NPIN        (NPIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .pCLK    (pCLK),
        .pRESET  (pRESET),
        .gpio_in (gpio_in),
        .sync_in (sync_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign off     = pADDR[ADDR_DEC_W-1:0];
    assign reg_idx = gpio_reg_e'(off[4:2]);
    assign wdata_n = pWDATA[NPIN-1:0];
    assign access  = pSEL & pENABLE;
    assign pREADY  = access & (cnt_q == 4'(WAIT_STATES)) & ~pRESET;

    // Error decode: out-of-window, misaligned, or wrong direction for the register
    always_comb begin
        err = 1'b0;
        if (off > OFF_DOUT_CLR || off[1:0] != 2'b00) begin
            err = 1'b1;
        end else if (pWRITE && reg_idx == REG_DIN) begin
            err = 1'b1;
        end else if (!pWRITE && (reg_idx == REG_DOUT_SET || reg_idx == REG_DOUT_CLR)) begin
            err = 1'b1;
        end
    end

    assign pSLVERR   = pREADY & err;
    assign wr_commit = pREADY & pWRITE & ~err;

    // Wait-state counter restarts for every transfer and after completion
    always_ff @(posedge pCLK) begin
        if (pRESET || !access || pREADY) cnt_q <= '0;
        else                             cnt_q <= cnt_q + 4'd1;
    end

    assign events = ~dir_q & ((rise_en_q & rise) | (fall_en_q & fall));
    assign w1c    = (wr_commit && reg_idx == REG_STATUS) ? wdata_n : '0;

    // Register file; STATUS sets take priority over a same-cycle clear
    always_ff @(posedge pCLK) begin
        if (pRESET) begin
            dout_q    <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            status_q <= (status_q & ~w1c) | events;
            if (wr_commit) begin
                case (reg_idx)
                    REG_DOUT:     dout_q    <= wdata_n;
                    REG_DIR:      dir_q     <= wdata_n;
                    REG_RISE_EN:  rise_en_q <= wdata_n;
                    REG_FALL_EN:  fall_en_q <= wdata_n;
                    REG_DOUT_SET: dout_q    <= dout_q | wdata_n;
                    REG_DOUT_CLR: dout_q    <= dout_q & ~wdata_n;
                    default:      ;
                endcase
            end
        end
    end

    // Read mux, zero outside a completed good read
    always_comb begin
        pRDATA = '0;
        if (pREADY && !pWRITE && !err) begin
            case (reg_idx)
                REG_DIN:     pRDATA[NPIN-1:0] = sync_in;
                REG_DOUT:    pRDATA[NPIN-1:0] = dout_q;
                REG_DIR:     pRDATA[NPIN-1:0] = dir_q;
                REG_RISE_EN: pRDATA[NPIN-1:0] = rise_en_q;
                REG_FALL_EN: pRDATA[NPIN-1:0] = fall_en_q;
                REG_STATUS:  pRDATA[NPIN-1:0] = status_q;
                default:     ;
            endcase
        end
    end

    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb/tb_apb_gpio_irq.sv - directed vector bench for apb_gpio_irq
module tb_apb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic [31:0] addr, wdata;
    logic        sel, sel3, en, wr;
    logic [15:0] gpio_in;

    logic [31:0] rdata, rdata3;
    logic        ready, ready3, slverr, slverr3;
    logic [15:0] gpio_out, gpio_oe, gpio_out3, gpio_oe3;
    logic        irq, irq3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_gpio_irq #(.WAIT_STATES(0)) dut (
        .pCLK(clk), .pRESET(rst), .pADDR(addr), .pSEL(sel), .pENABLE(en),
        .pWRITE(wr), .pWDATA(wdata), .pRDATA(rdata), .pREADY(ready),
        .pSLVERR(slverr), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    apb_gpio_irq #(.WAIT_STATES(3)) dut3 (
        .pCLK(clk), .pRESET(rst3), .pADDR(addr), .pSEL(sel3), .pENABLE(en),
        .pWRITE(wr), .pWDATA(wdata), .pRDATA(rdata3), .pREADY(ready3),
        .pSLVERR(slverr3), .gpio_in(gpio_in), .gpio_out(gpio_out3),
        .gpio_oe(gpio_oe3), .irq(irq3)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One APB transfer starting at a negedge; returns at the negedge after completion
    task automatic xfer(input bit w3, input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits);
        bit timeout;
        addr = a; wr = w; wdata = d; en = 1'b0;
        if (w3) sel3 = 1'b1; else sel = 1'b1;
        @(negedge clk);
        en = 1'b1;
        #1;
        waits = 0;
        timeout = 1'b0;
        while (!(w3 ? ready3 : ready)) begin
            waits++;
            if (waits > 20) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("xfer_timeout", {31'd0, timeout}, 32'd0);
        rd  = w3 ? rdata3 : rdata;
        err = w3 ? slverr3 : slverr;
        @(negedge clk);
        sel = 1'b0; sel3 = 1'b0; en = 1'b0;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, a, 1'b1, d, rd, err, waits);
        check("wr_err", {31'd0, err}, 32'd0);
    endtask

    task automatic rd0(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic err; int waits;
        xfer(1'b0, a, 1'b0, 32'd0, rd, err, waits);
        check(name, rd, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          waits;

        tbl[0]  = '{32'h00, 1'b0, 32'h0,        32'h0000A5A5, 1'b0};
        tbl[1]  = '{32'h08, 1'b1, 32'h000000FF, 32'h0,        1'b0};
        tbl[2]  = '{32'h04, 1'b1, 32'h00000F0F, 32'h0,        1'b0};
        tbl[3]  = '{32'h18, 1'b1, 32'h0000F000, 32'h0,        1'b0};
        tbl[4]  = '{32'h1C, 1'b1, 32'h0000000F, 32'h0,        1'b0};
        tbl[5]  = '{32'h04, 1'b0, 32'h0,        32'h0000FF00, 1'b0};
        tbl[6]  = '{32'h08, 1'b0, 32'h0,        32'h000000FF, 1'b0};
        tbl[7]  = '{32'h00, 1'b1, 32'h00001234, 32'h0,        1'b1};
        tbl[8]  = '{32'h20, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[9]  = '{32'h18, 1'b0, 32'h0,        32'h0,        1'b1};
        tbl[10] = '{32'h06, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[11] = '{32'h04, 1'b0, 32'h0,        32'h0000FF00, 1'b0};
        tbl[12] = '{32'h0C, 1'b1, 32'hFFFF0000, 32'h0,        1'b0};
        tbl[13] = '{32'h0C, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[14] = '{32'h14, 1'b0, 32'h0,        32'h0,        1'b0};

        rst = 1'b1; rst3 = 1'b1;
        sel = 1'b0; sel3 = 1'b0; en = 1'b0; wr = 1'b0;
        addr = '0; wdata = '0;
        gpio_in = 16'hA5A5;
        idle(2);
        check("reset_out", {16'd0, gpio_out}, 32'd0);
        check("reset_oe",  {16'd0, gpio_oe},  32'd0);
        check("reset_irq", {31'd0, irq},      32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_slverr", {31'd0, slverr}, 32'd0);
        rst = 1'b0; rst3 = 1'b0;
        idle(3);

        for (int i = 0; i < NV; i++) begin
            xfer(1'b0, tbl[i].addr, tbl[i].wr, tbl[i].wdata, rd, err, waits);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
            check($sformatf("vec%0d_waits", i), waits, 32'd0);
            if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        check("gpio_oe", {16'd0, gpio_oe}, 32'h000000FF);
        check("gpio_out", {16'd0, gpio_out}, 32'h0000FF00);
        check("irq_idle", {31'd0, irq}, 32'd0);

        // Rising edge on pin 8: irq appears two edges after the synchroniser capture
        gpio_in = 16'h0000;
        idle(4);
        wr0(32'h0C, 32'h00000100);
        gpio_in[8] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rise_irq_t1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("rise_irq_t2", {31'd0, irq}, 32'd1);
        rd0("status_rise", 32'h14, 32'h00000100);
        wr0(32'h14, 32'h00000100);
        rd0("status_cleared", 32'h14, 32'h0);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Fall on pin 9 colliding with a W1C of the same bit
        gpio_in[9] = 1'b1;
        idle(4);
        wr0(32'h10, 32'h00000200);
        gpio_in[9] = 1'b0;
        idle(4);
        rd0("status_fall", 32'h14, 32'h00000200);
        gpio_in[9] = 1'b1;
        idle(4);
        gpio_in[9] = 1'b0;
        @(negedge clk);
        wr0(32'h14, 32'h00000200);
        rd0("status_set_wins", 32'h14, 32'h00000200);
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        wr0(32'h14, 32'h00000200);
        rd0("status_clr2", 32'h14, 32'h0);

        // Output pins raise no events
        wr0(32'h08, 32'h000001FF);
        gpio_in[8] = 1'b0;
        idle(4);
        gpio_in[8] = 1'b1;
        idle(4);
        rd0("status_output_pin", 32'h14, 32'h0);
        check("irq_output_pin", {31'd0, irq}, 32'd0);

        // Three-wait-state instance
        xfer(1'b1, 32'h04, 1'b1, 32'h00001234, rd, err, waits);
        check("ws3_waits_wr", waits, 32'd3);
        check("ws3_err", {31'd0, err}, 32'd0);
        check("ws3_dout", {16'd0, gpio_out3}, 32'h00001234);
        xfer(1'b1, 32'h04, 1'b0, 32'h0, rd, err, waits);
        check("ws3_waits_rd", waits, 32'd3);
        check("ws3_rdata", rd, 32'h00001234);

        // Reset mid-access abandons the transfer
        addr = 32'h08; wr = 1'b1; wdata = 32'h0000BEEF; sel3 = 1'b1; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("ws3_ready_in_reset", {31'd0, ready3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0; sel3 = 1'b0; en = 1'b0;
        @(negedge clk);
        check("ws3_no_commit_oe", {16'd0, gpio_oe3}, 32'd0);
        check("ws3_reset_out", {16'd0, gpio_out3}, 32'd0);
        xfer(1'b1, 32'h04, 1'b1, 32'h00005A5A, rd, err, waits);
        check("ws3_waits_after_rst", waits, 32'd3);
        check("ws3_dout_after_rst", {16'd0, gpio_out3}, 32'h00005A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised successor to the team's fixed 16-bit APB LED/switch GPIO.
- APB3 slave exposing NPIN bidirectional GPIO pins. Supports:
  - per-pin direction
  - atomic set/clear of outputs
  - synchronised inputs
  - per-pin rising/falling-edge interrupts with sticky write-1-to-clear status
  - configurable wait states
- Sits on the MCS APB bus beside the other peripherals; irq goes to the processor interrupt input.

Parameters:
- DW, 32, APB data width.
- AW, 32, APB address width.
- NPIN, 16, number of GPIO pins (1..DW).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- WAIT_STATES, 0, extra access-phase cycles before pREADY (0..15).

Ports:
- pCLK  in  1  clock.
- pRESET  in  1  reset. One clock; reset is synchronous and active-high.
- pADDR  in  AW  APB address; only pADDR[6:0] decoded.
- pSEL  in  1  peripheral select.
- pENABLE  in  1  access phase.
- pWRITE  in  1  1=write, 0=read.
- pWDATA  in  DW  write data.
- pRDATA  out  DW  read data.
- pREADY  out  1  transfer complete.
- pSLVERR  out  1  error response, valid with pREADY.
- gpio_in  in  NPIN  pad inputs (asynchronous).
- gpio_out  out  NPIN  pad output values.
- gpio_oe  out  NPIN  pad output enables (1=drive).
- irq  out  1  level interrupt.

Behaviour:
- Register map, byte offsets; bits above NPIN read 0 and ignore writes:
  - 0x00 DIN: RO, synchronised gpio_in.
  - 0x04 DOUT: RW.
  - 0x08 DIR: RW, 1=output.
  - 0x0C RISE_EN: RW.
  - 0x10 FALL_EN: RW.
  - 0x14 STATUS: read; write 1 clears.
  - 0x18 DOUT_SET: WO, DOUT |= wdata.
  - 0x1C DOUT_CLR: WO, DOUT &= ~wdata.
- Reset values:
  - All registers 0.
  - gpio_out=0, gpio_oe=0, irq=0, pRDATA=0, pSLVERR=0.
  - Synchroniser and edge-history flops 0.
- Wait-state counter:
  - Clears when !(pSEL&pENABLE) or when pREADY=1.
  - Otherwise increments while pSEL&pENABLE.
- pREADY = pSEL & pENABLE & (cnt==WAIT_STATES) & !pRESET, combinational.
  - WAIT_STATES=0 gives zero-wait access.
  - pREADY=0 during reset.
- Write commit:
  - Occurs on the pCLK edge where pSEL&pENABLE&pWRITE&pREADY.
  - Exactly one commit per transfer.
- pRDATA:
  - Selected register when pSEL&pENABLE&!pWRITE&pREADY; otherwise 0. Combinational.
  - Write-only offsets are not readable.
- pSLVERR (combinational, qualified by pREADY) is high for any of:
  - offset > 0x1C
  - pADDR[1:0] != 0
  - write to DIN
  - read of DOUT_SET or DOUT_CLR
- An errored transfer changes no state.
- Outputs: gpio_out = DOUT, gpio_oe = DIR, driven directly from the registers.
- Input path:
  - SYNC_STAGES flop chain produces sync_in.
  - prev <= sync_in every cycle.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
- STATUS[i] sets when DIR[i]==0 and either (RISE_EN[i]&rise[i]) or (FALL_EN[i]&fall[i]).
- Latency with SYNC_STAGES=2: pin change before edge t gives DIN updated after t+1 and STATUS/irq after t+2.
- Simultaneous STATUS W1C and new event on the same bit: set wins, bit stays 1.
- Enabling RISE_EN/FALL_EN never reports past edges; only edges after the enable write commits are captured.
- Changing a pin to output stops new events; existing STATUS bits remain until cleared.
- irq = |STATUS, combinational from the register; no separate mask beyond the enables.
- Reset mid-transfer:
  - Transfer abandoned, no commit, counter cleared.
  - The master must restart the transfer after reset.

Decomposition:
- Package apb_gpio_pkg holds:
  - offset constants OFF_DIN..OFF_DOUT_CLR
  - enum gpio_reg_e for decoded register index
  - localparam ADDR_DEC_W=7
- Sub-module gpio_in_sync holds the synchroniser chain, prev flop and rise/fall outputs.
  - Parameters NPIN and SYNC_STAGES.
  - Ports pCLK, pRESET, gpio_in, sync_in, rise, fall.

Test Plan:
- Reset then read 0x00 with gpio_in=16'hA5A5 (waiting 3 cycles) -> pRDATA=32'h0000A5A5, pSLVERR=0; gpio_out=0, gpio_oe=0, irq=0.
- Write DIR=16'h00FF, DOUT=16'h0F0F, DOUT_SET=16'hF000, DOUT_CLR=16'h000F -> gpio_oe=16'h00FF, gpio_out=16'hFF00, read 0x04 returns 32'h0000FF00.
- RISE_EN=16'h0100, pin 8 goes 0->1 -> STATUS=16'h0100 and irq=1 two edges after sync capture; write 0x14 with 16'h0100 -> STATUS=0, irq=0.
- Same-cycle W1C of STATUS bit 9 and a fall event on bit 9 with FALL_EN[9]=1 -> STATUS[9] stays 1, irq stays 1.
- Write 0x00, write 0x20, read 0x18, write 0x06 -> each gets pREADY with pSLVERR=1; all registers unchanged.
- WAIT_STATES=3 build: any transfer -> pREADY low for 3 access cycles, high on the 4th; exactly one write commit; pulse pRESET mid-access -> no commit, next transfer behaves normally.
